// File: rtl/sw_cond_pkg.sv
// Shared encodings and default sizing for the switch conditioner.
package sw_cond_pkg;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_EVENT    = 1'b1;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int TICK_DIV_DEF        = 4;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch line: metastability synchroniser, debounce counter, stable flop.
// stable_next exposes the value stable will take at the coming edge so the
// top level can raise its strobe on the same edge sw_out changes.
module sw_debounce_bit
    import sw_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic stable_next
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_next;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];

    // Shift the raw level through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], raw};
    end

    // Qualify a change: DEBOUNCE_CYCLES consecutive mismatches commit it,
    // any single matching cycle restarts the count.
    always_comb begin
        stable_next = stable;
        cnt_next    = '0;
        if (synced != stable) begin
            if (cnt == CNT_MAX) stable_next = synced;
            else                cnt_next    = cnt + 1'b1;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            stable <= stable_next;
            cnt    <= cnt_next;
        end
    end

endmodule

// File: rtl/sw_conditioner.sv
// Conditions two raw switch lines into a clean 2-bit value and a one-cycle
// advance strobe for the downstream switch-driven FSM.
module sw_conditioner
    import sw_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int TICK_DIV        = TICK_DIV_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sw_raw,
    input  logic       mode,
    input  logic       hold,
    output logic [1:0] sw_out,
    output logic       ctrl_out
);

    localparam int            DW      = cnt_width(TICK_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

    logic [1:0]    stable;
    logic [1:0]    stable_next;
    logic [DW-1:0] div;
    logic          strobe_next;

    for (genvar i = 0; i < 2; i++) begin : g_bit
        sw_debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk        (clk),
            .reset      (reset),
            .raw        (sw_raw[i]),
            .stable     (stable[i]),
            .stable_next(stable_next[i])
        );
    end

    assign sw_out = stable;

    // Free-running tick divider, frozen while hold is high.
    always_ff @(posedge clk) begin
        if (reset)      div <= '0;
        else if (!hold) div <= (div == DIV_MAX) ? '0 : div + 1'b1;
    end

    // Strobe source mux. In event mode the strobe is masked for one cycle
    // after a pulse so staggered bit updates can never form a 2-cycle pulse.
    always_comb begin
        strobe_next = 1'b0;
        if (hold)                       strobe_next = 1'b0;
        else if (mode == MODE_PERIODIC) strobe_next = (div == DIV_MAX);
        else                            strobe_next = (stable_next != stable) && !ctrl_out;
    end

    // Registered strobe output.
    always_ff @(posedge clk) begin
        if (reset) ctrl_out <= 1'b0;
        else       ctrl_out <= strobe_next;
    end

endmodule
